// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional early-out for zero operands / divide-by-zero when MDU_FAST_EN is defined.
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [2*XLEN-1:0]   p_q, p_d;
  logic [XLEN-1:0]     m_q, m_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [XLEN-1:0]     res_q, res_d;
`ifdef MDU_FAST_EN
  logic                fast_q, fast_d;
`endif

  // Request decode: operand signedness and magnitudes
  logic            is_div_i, sa_i, sb_i, b_zero_i;
  logic [XLEN-1:0] mag_a_i, mag_b_i;

  always_comb begin
    is_div_i = req_op[2];
    b_zero_i = (req_b == '0);
    if (is_div_i) begin
      sa_i = ~req_op[0] & req_a[XLEN-1];
      sb_i = ~req_op[0] & req_b[XLEN-1];
    end else begin
      sa_i = (req_op[1:0] == 2'b01 || req_op[1:0] == 2'b10) & req_a[XLEN-1];
      sb_i = (req_op[1:0] == 2'b01) & req_b[XLEN-1];
    end
    mag_a_i = cond_neg(sa_i, req_a);
    mag_b_i = cond_neg(sb_i, req_b);
  end

  // One iteration of either algorithm, plus final sign correction
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] p_mul, p_div, p_nx, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_calc, res_sel;
  logic              fin;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
    p_mul    = {mul_sum, p_q[XLEN-1:1]};
    rem_sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, m_q};
    p_div    = div_diff[XLEN] ? {rem_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    p_nx     = op_q[2] ? p_div : p_mul;
    prod_fix = cond_neg2(neg_q, p_nx);
    quo_fix  = cond_neg(neg_q, p_nx[XLEN-1:0]);
    rem_fix  = cond_neg(rneg_q, p_nx[2*XLEN-1:XLEN]);
    case (op_q)
      3'd0:          res_calc = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          res_calc = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    res_calc = quo_fix;
      default:       res_calc = rem_fix;
    endcase
`ifdef MDU_FAST_EN
    fin     = fast_q || (cnt_q == LAST);
    res_sel = fast_q ? m_q : res_calc;
`else
    fin     = (cnt_q == LAST);
    res_sel = res_calc;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    p_d     = p_q;
    m_d     = m_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
`ifdef MDU_FAST_EN
    fast_d  = fast_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          cnt_d   = '0;
          // Divide-by-zero keeps an unsigned all-ones quotient; remainder sign restores a
          neg_d   = (sa_i ^ sb_i) & ~(is_div_i & b_zero_i);
          rneg_d  = sa_i;
          m_d     = is_div_i ? mag_b_i : mag_a_i;
          p_d     = {{XLEN{1'b0}}, (is_div_i ? mag_a_i : mag_b_i)};
          state_d = S_CALC;
`ifdef MDU_FAST_EN
          fast_d  = is_div_i ? b_zero_i : (b_zero_i || (req_a == '0));
          if (fast_d)
            m_d = is_div_i ? (req_op[1] ? req_a : {XLEN{1'b1}}) : '0;
`endif
        end
      end
      S_CALC: begin
        p_d   = p_nx;
        cnt_d = cnt_q + 1'b1;
        if (fin) begin
          res_d   = res_sel;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      p_q     <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
`ifdef MDU_FAST_EN
      fast_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      p_q     <= p_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
`ifdef MDU_FAST_EN
      fast_q  <= fast_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign resp_data  = res_q;

endmodule
